trace_out_checker: RTL
======================

Name: trace_out_checker

Overview:
- Downstream consumer of the fuzzing harness's 96-bit output, delivered as three 32-bit words per simulation step.
- Compares each step's DUT outputs against a golden model's outputs (second simulator instance) and folds the DUT outputs into a running 32-bit signature.
- Latches the first mismatch.
- At end of run, streams a 6-word report over a valid/ready interface to the host collector.

Parameters:
- SIG_SEED, 32'h0000_0000, initial signature value loaded on start.
- STOP_ON_MISMATCH, 1, 1: first mismatch ends the run immediately. 0: run continues to n_steps_i with mismatch flag held.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  pulse; begins a run (accepted in IDLE or DONE only)
- n_steps_i  input  32  number of steps in the run; sampled on accepted start_i
- step_valid_i  input  1  one step's outputs present this cycle (no backpressure; always accepted in RUN)
- out_0_i, out_1_i, out_2_i  input  32 each  DUT output words [31:0], [63:32], [95:64]
- gold_0_i, gold_1_i, gold_2_i  input  32 each  golden output words, same layout
- busy_o  output  1  high in RUN or REPORT
- mismatch_o  output  1  sticky first-mismatch flag for current/last run
- rpt_valid_o  output  1  report word valid
- rpt_data_o  output  32  report word
- rpt_ready_i  input  1  consumer accepts report word
- done_o  output  1  high in DONE

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0.
  - step_cnt = 0, mm_step = 0, diffs = 0, sig = SIG_SEED, word index = 0.
- States: IDLE, RUN, REPORT, DONE.
- IDLE/DONE + start_i:
  - Go to RUN.
  - Load sig = SIG_SEED; clear step_cnt, mismatch_o, mm_step, diffs.
  - Latch n_steps_i.
  - If n_steps_i == 0, go straight to REPORT instead.
- start_i is ignored in RUN and REPORT.
- RUN, step_valid_i = 1:
  - sig <= rotl(sig,1) ^ out_0 ^ rotl(out_1,11) ^ rotl(out_2,22).
  - rotl(x,k) = {x[31-k:0], x[31:32-k]}.
  - step_cnt <= step_cnt + 1 (32-bit, wraps; no saturation).
- Mismatch: in RUN with step_valid_i, if any out_k != gold_k and mismatch_o == 0:
  - mismatch_o <= 1.
  - mm_step <= current step_cnt (0-based index of this step).
  - diff_k <= out_k ^ gold_k.
  - Later mismatches do not overwrite these.
- RUN exit, evaluated after the step update:
  - If step_cnt+1 == n_steps, go to REPORT.
  - Else if this step mismatched and STOP_ON_MISMATCH = 1, go to REPORT.
  - The sig/count/mismatch updates of the exiting step are included in the report.
- RUN, step_valid_i = 0: no change.
- REPORT:
  - rpt_valid_o = 1; rpt_data_o selected by word index 0..5:
    - 0: step_cnt
    - 1: sig
    - 2: mm_step (0 if no mismatch)
    - 3: diff_0
    - 4: diff_1
    - 5: diff_2
  - rpt_data_o is registered/stable while valid && !ready.
  - Word advances on rpt_valid_o && rpt_ready_i.
  - Handshake on word 5: go to DONE, index reset to 0.
  - step_valid_i is ignored in REPORT and DONE.
- DONE: done_o = 1. Results and mismatch_o hold until next accepted start_i or rst.
- rst asserted in any state, including mid-RUN or mid-REPORT: return to reset values next cycle, no partial report.
- Latency: step result visible in sig/mismatch_o one cycle after the step_valid_i cycle. First report word valid in the cycle after entering REPORT.

Decomposition:
- Shared package trace_chk_pkg:
  - state enum {IDLE, RUN, REPORT, DONE}
  - RPT_WORDS = 6
  - report word index constants
  - rotl32 function
- One natural sub-module: trace_sig_acc (combinational signature next-state plus registered sig with seed load).
- Remainder in the top FSM.

Test Plan:
- SIG_SEED=0, n_steps=2, steps (out=1,0,0; gold equal) twice -> sig after step1 = 1, after step2 = 3; report = {2, 3, 0, 0, 0, 0}; mismatch_o=0; done_o=1.
- n_steps=3, STOP_ON_MISMATCH=1, step 1 (0-based) has out_2=32'hF0, gold_2=32'h0F -> REPORT after step 1; report = {2, sig, 1, 0, 0, 32'hFF}; third step_valid_i ignored.
- STOP_ON_MISMATCH=0, mismatches at steps 1 and 3 of 5 -> run completes 5 steps; mm_step=1; diffs from step 1 only.
- n_steps=0 on start -> REPORT next cycle; report = {0, SIG_SEED, 0, 0, 0, 0}.
- rpt_ready_i low for 3 cycles on word 1 -> rpt_valid_o stays 1, rpt_data_o stable; all 6 words delivered in order once ready.
- rst pulsed during REPORT word 3, then start_i -> all outputs 0 after rst; fresh run from SIG_SEED with correct report.

Source files
------------

// File: rtl/trace_chk_pkg.sv
// Shared types and helpers for the trace output checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package trace_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int RPT_WORDS = 6;

  // Report word order as seen by the host collector.
  localparam logic [2:0] WI_STEP  = 3'd0;
  localparam logic [2:0] WI_SIG   = 3'd1;
  localparam logic [2:0] WI_MM    = 3'd2;
  localparam logic [2:0] WI_DIFF0 = 3'd3;
  localparam logic [2:0] WI_DIFF1 = 3'd4;
  localparam logic [2:0] WI_DIFF2 = 3'd5;
  localparam logic [2:0] WI_LAST  = 3'(RPT_WORDS - 1);

  // Rotate left; k must be in 1..31.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned k);
    rotl32 = (x << k) | (x >> (32 - k));
  endfunction

endpackage

// File: rtl/trace_out_checker_if.sv
// Step input bus (DUT + golden words) and report output stream of the checker.
// Latency: n/a (wiring only).
// Backpressure: step bus has none; report stream is valid/ready.
interface trace_out_checker_if;
  logic        step_valid_i;
  logic [31:0] out_0_i;
  logic [31:0] out_1_i;
  logic [31:0] out_2_i;
  logic [31:0] gold_0_i;
  logic [31:0] gold_1_i;
  logic [31:0] gold_2_i;
  logic        rpt_valid_o;
  logic [31:0] rpt_data_o;
  logic        rpt_ready_i;

  // Harness / host side: drives steps, consumes the report.
  modport master (
    output step_valid_i, out_0_i, out_1_i, out_2_i, gold_0_i, gold_1_i, gold_2_i,
    output rpt_ready_i,
    input  rpt_valid_o, rpt_data_o
  );

  // Checker side.
  modport slave (
    input  step_valid_i, out_0_i, out_1_i, out_2_i, gold_0_i, gold_1_i, gold_2_i,
    input  rpt_ready_i,
    output rpt_valid_o, rpt_data_o
  );
endinterface

// File: rtl/trace_sig_acc.sv
// Running 32-bit signature of DUT output words, seeded on load.
// Latency: folded value visible one cycle after i_step_vld.
// Backpressure: none; every qualified step is absorbed.
// Ports: clk/rst; i_load reloads SIG_SEED; i_step_vld + i_out_0..2 fold a step; o_sig = current signature.
module trace_sig_acc
  import trace_chk_pkg::*;
#(
  parameter logic [31:0] SIG_SEED = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step_vld,
  input  logic [31:0] i_out_0,
  input  logic [31:0] i_out_1,
  input  logic [31:0] i_out_2,
  output logic [31:0] o_sig
);

  logic [31:0] r_sig;
  logic [31:0] w_sig_nxt;

  // Distinct rotations per word keep equal values in different lanes from cancelling.
  assign w_sig_nxt = rotl32(r_sig, 1) ^ i_out_0 ^ rotl32(i_out_1, 11) ^ rotl32(i_out_2, 22);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig <= SIG_SEED;
    end else if (i_load) begin
      r_sig <= SIG_SEED;
    end else if (i_step_vld) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/trace_out_checker.sv
// Compares DUT vs golden step outputs, signs DUT outputs, latches first mismatch, streams a 6-word report.
// Latency: step effect visible next cycle; first report word valid the cycle after entering REPORT.
// Backpressure: steps never stall; report word and data hold while rpt_ready_i is low.
// Ports: clk/rst; start_i + n_steps_i launch a run; bus carries steps and report; busy_o/mismatch_o/done_o status.
module trace_out_checker
  import trace_chk_pkg::*;
#(
  parameter logic [31:0] SIG_SEED         = 32'h0000_0000,
  parameter bit          STOP_ON_MISMATCH = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [31:0]               n_steps_i,
  trace_out_checker_if.slave        bus,
  output logic                      busy_o,
  output logic                      mismatch_o,
  output logic                      done_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_n_steps;
  logic [31:0] r_step_cnt;
  logic [31:0] r_mm_step;
  logic [31:0] r_diff_0;
  logic [31:0] r_diff_1;
  logic [31:0] r_diff_2;
  logic        r_mismatch;
  logic [2:0]  r_idx;

  logic        w_start;
  logic        w_step;
  logic        w_step_mm;
  logic        w_rpt_hs;
  logic        w_rpt_vld;
  logic [31:0] w_cnt_inc;
  logic [31:0] w_sig;
  logic [31:0] w_rpt_dat;

  assign w_start   = start_i && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_step    = bus.step_valid_i && (r_state == ST_RUN);
  assign w_step_mm = w_step && ((bus.out_0_i != bus.gold_0_i) ||
                                (bus.out_1_i != bus.gold_1_i) ||
                                (bus.out_2_i != bus.gold_2_i));
  assign w_cnt_inc = r_step_cnt + 32'd1;
  assign w_rpt_hs  = (r_state == ST_REPORT) && bus.rpt_ready_i;

  trace_sig_acc #(.SIG_SEED(SIG_SEED)) u_sig (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_start),
    .i_step_vld (w_step),
    .i_out_0    (bus.out_0_i),
    .i_out_1    (bus.out_1_i),
    .i_out_2    (bus.out_2_i),
    .o_sig      (w_sig)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    w_rpt_vld   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        done_o = (r_state == ST_DONE);
        if (w_start) w_state_nxt = (n_steps_i == 32'd0) ? ST_REPORT : ST_RUN;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        // The exiting step's own updates land in the same edge, so the report sees them.
        if (w_step) begin
          if (w_cnt_inc == r_n_steps)              w_state_nxt = ST_REPORT;
          else if (w_step_mm && STOP_ON_MISMATCH)  w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        busy_o    = 1'b1;
        w_rpt_vld = 1'b1;
        if (w_rpt_hs && r_idx == WI_LAST) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n_steps  <= '0;
      r_step_cnt <= '0;
      r_mm_step  <= '0;
      r_diff_0   <= '0;
      r_diff_1   <= '0;
      r_diff_2   <= '0;
      r_mismatch <= 1'b0;
      r_idx      <= '0;
    end else if (w_start) begin
      r_n_steps  <= n_steps_i;
      r_step_cnt <= '0;
      r_mm_step  <= '0;
      r_diff_0   <= '0;
      r_diff_1   <= '0;
      r_diff_2   <= '0;
      r_mismatch <= 1'b0;
      r_idx      <= '0;
    end else begin
      if (w_step) begin
        r_step_cnt <= w_cnt_inc;
        // Only the first mismatch of a run is recorded.
        if (w_step_mm && !r_mismatch) begin
          r_mismatch <= 1'b1;
          r_mm_step  <= r_step_cnt;
          r_diff_0   <= bus.out_0_i ^ bus.gold_0_i;
          r_diff_1   <= bus.out_1_i ^ bus.gold_1_i;
          r_diff_2   <= bus.out_2_i ^ bus.gold_2_i;
        end
      end
      if (w_rpt_hs) r_idx <= (r_idx == WI_LAST) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Sources are frozen in REPORT, so the muxed word is stable while stalled.
  always_comb begin
    w_rpt_dat = '0;
    case (r_idx)
      WI_STEP:  w_rpt_dat = r_step_cnt;
      WI_SIG:   w_rpt_dat = w_sig;
      WI_MM:    w_rpt_dat = r_mm_step;
      WI_DIFF0: w_rpt_dat = r_diff_0;
      WI_DIFF1: w_rpt_dat = r_diff_1;
      WI_DIFF2: w_rpt_dat = r_diff_2;
      default:  w_rpt_dat = '0;
    endcase
  end

  assign bus.rpt_valid_o = w_rpt_vld;
  assign bus.rpt_data_o  = w_rpt_vld ? w_rpt_dat : 32'd0;
  assign mismatch_o      = r_mismatch;

endmodule
